// File: rtl/conv_pkg.sv
// Shared types and constants for the conv MAC host sequencer.
// State encoding, tap/beat counts and the result-width helper.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_WRITE,
        S_READ,
        S_MAC,
        S_DONE
    } state_t;

    localparam int NUM_TAPS   = 9;
    localparam int LOAD_BEATS = 18;

    function automatic int RES_W(input int d_w);
        return 2 * d_w + 2;
    endfunction

endpackage

// File: rtl/conv_seq_loader.sv
// Serial-to-parallel loader: 18 beats fill the packed A window, then B filter.
// load_done pulses combinationally on the accepting cycle of the last beat.
module conv_seq_loader
    import conv_pkg::*;
#(
    parameter int D_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    take,
    input  logic [D_W-1:0]          data,
    output logic                    load_done,
    output logic [NUM_TAPS*D_W-1:0] a,
    output logic [NUM_TAPS*D_W-1:0] b
);

    logic [4:0] beat;

    assign load_done = take && (beat == 5'(LOAD_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
            a    <= '0;
            b    <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (take) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                if (beat == 5'(j))
                    a[D_W*j +: D_W] <= data;
                if (beat == 5'(j + NUM_TAPS))
                    b[D_W*j +: D_W] <= data;
            end
            beat <= load_done ? '0 : beat + 5'd1;
        end
    end

endmodule

// File: rtl/conv_seq.sv
// Host sequencer for one conv MAC instance: load, clr/write/read/MAC, return Y.
// Build option CONV_SEQ_RELU_EN clamps a negative captured result to zero.
module conv_seq
    import conv_pkg::*;
#(
    parameter int D_W     = 32,
    parameter int WR_CYC  = 9,
    parameter int MAC_CYC = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [D_W-1:0]          in_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [RES_W(D_W)-1:0]   res_data,
    output logic                    busy,
    output logic                    conv_clk_en,
    output logic                    conv_clr,
    output logic                    conv_en_wr,
    output logic                    conv_en_rd,
    output logic                    conv_wr,
    output logic                    conv_en_mac,
    output logic                    conv_en_mac_out,
    output logic [NUM_TAPS*D_W-1:0] conv_a,
    output logic [NUM_TAPS*D_W-1:0] conv_b,
    input  logic [RES_W(D_W)-1:0]   conv_y
);

    localparam int Y_W = RES_W(D_W);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] phase;
    logic       take;
    logic       load_done;
    logic       wr_last;
    logic       mac_last;

    assign take     = in_valid && in_ready;
    assign wr_last  = phase == 8'(WR_CYC - 1);
    assign mac_last = phase == 8'(MAC_CYC - 1);

    conv_seq_loader #(.D_W(D_W)) u_loader (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == S_DONE && res_ready),
        .take      (take),
        .data      (in_data),
        .load_done (load_done),
        .a         (conv_a),
        .b         (conv_b)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (take) state_nxt = S_LOAD;
            S_LOAD:  if (load_done) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_WRITE;
            S_WRITE: if (wr_last) state_nxt = S_READ;
            S_READ:  state_nxt = S_MAC;
            S_MAC:   if (mac_last) state_nxt = S_DONE;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            phase           <= '0;
            in_ready        <= 1'b0;
            busy            <= 1'b0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            conv_clk_en     <= 1'b0;
            conv_clr        <= 1'b0;
            conv_en_wr      <= 1'b0;
            conv_en_rd      <= 1'b0;
            conv_wr         <= 1'b0;
            conv_en_mac     <= 1'b0;
            conv_en_mac_out <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                phase <= '0;
            else if (state == S_WRITE || state == S_MAC)
                phase <= phase + 8'd1;
            else
                phase <= '0;
            in_ready        <= state_nxt inside {S_IDLE, S_LOAD};
            busy            <= state_nxt != S_IDLE;
            res_valid       <= state_nxt == S_DONE;
            conv_clk_en     <= state_nxt inside {S_CLR, S_WRITE, S_READ, S_MAC};
            conv_clr        <= state_nxt == S_CLR;
            conv_en_wr      <= state_nxt == S_WRITE;
            conv_wr         <= state_nxt == S_WRITE;
            conv_en_rd      <= state_nxt inside {S_READ, S_MAC};
            conv_en_mac     <= state_nxt == S_MAC;
            conv_en_mac_out <= state_nxt == S_MAC;
            if (state == S_MAC && mac_last) begin
`ifdef CONV_SEQ_RELU_EN
                res_data <= conv_y[Y_W-1] ? '0 : conv_y;
`else
                res_data <= conv_y;
`endif
            end
        end
    end

endmodule
